// File: rtl/ssd1309_pkg.sv
// Shared opcodes, command FSM states and argument helpers for the SSD1309 SPI sink.
package ssd1309_pkg;

  localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COL_S = 3'd1,
    ST_COL_E = 3'd2,
    ST_PG_S  = 3'd3,
    ST_PG_E  = 3'd4,
    ST_SKIP1 = 3'd5
  } cmd_state_e;

  // Commands whose single argument byte is consumed and ignored.
  function automatic logic takes_one_arg(input logic [7:0] op);
    logic r;
    case (op)
      8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
      8'hD5, 8'hD9, 8'hDA, 8'hDB: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] clamp_arg(input logic [7:0] arg, input logic [7:0] max_v);
    logic [7:0] r;
    if (arg > max_v) r = max_v;
    else             r = arg;
    return r;
  endfunction

endpackage

// File: rtl/ssd1309_spi_sink_if.sv
// 4-wire SPI + panel reset pins between ssd1309_driver (master) and the sink (slave).
interface ssd1309_spi_sink_if;
  logic sclk;
  logic sdin;
  logic dc;
  logic cs;
  logic res;

  modport master (output sclk, output sdin, output dc, output cs, output res);
  modport slave  (input  sclk, input  sdin, input  dc, input  cs, input  res);
endinterface

// File: rtl/ssd1309_spi_sink_spi_byte_rx.sv
// Oversampling SPI byte receiver: pin synchronisers, MSB-first shifter, framing check.
module spi_byte_rx
  import ssd1309_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  ssd1309_spi_sink_if.slave   spi,
  output logic                panel_rst,
  output logic                byte_valid,
  output logic [7:0]          byte_data,
  output logic                byte_is_data,
  output logic                frame_error
);

  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic sdin_s1_q, sdin_s2_q;
  logic dc_s1_q, dc_s2_q;
  logic cs_s1_q, cs_s2_q;
  logic res_s1_q, res_s2_q;
  logic sclk_rise_s;

  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       rx_done_q, rx_done_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_dc_q, rx_dc_d;
  logic       byte_valid_q, byte_valid_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_is_data_q, byte_is_data_d;
  logic       frame_error_q, frame_error_d;

  // Synchronisers idle deselected and out of panel reset; only the system reset touches them.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1_q <= 1'b0; sclk_s2_q <= 1'b0; sclk_s3_q <= 1'b0;
      sdin_s1_q <= 1'b0; sdin_s2_q <= 1'b0;
      dc_s1_q   <= 1'b0; dc_s2_q   <= 1'b0;
      cs_s1_q   <= 1'b1; cs_s2_q   <= 1'b1;
      res_s1_q  <= 1'b1; res_s2_q  <= 1'b1;
    end else begin
      sclk_s1_q <= spi.sclk; sclk_s2_q <= sclk_s1_q; sclk_s3_q <= sclk_s2_q;
      sdin_s1_q <= spi.sdin; sdin_s2_q <= sdin_s1_q;
      dc_s1_q   <= spi.dc;   dc_s2_q   <= dc_s1_q;
      cs_s1_q   <= spi.cs;   cs_s2_q   <= cs_s1_q;
      res_s1_q  <= spi.res;  res_s2_q  <= res_s1_q;
    end
  end

  assign sclk_rise_s = sclk_s2_q & ~sclk_s3_q;
  assign panel_rst   = reset | ~res_s2_q;

  always_comb begin
    shift_d        = shift_q;
    cnt_d          = cnt_q;
    rx_done_d      = 1'b0;
    rx_byte_d      = rx_byte_q;
    rx_dc_d        = rx_dc_q;
    frame_error_d  = 1'b0;
    byte_valid_d   = rx_done_q;
    byte_data_d    = byte_data_q;
    byte_is_data_d = byte_is_data_q;
    if (rx_done_q) begin
      byte_data_d    = rx_byte_q;
      byte_is_data_d = rx_dc_q;
    end else begin
      byte_data_d    = byte_data_q;
    end
    // Deselect drops any partial byte; report it only if bits were pending.
    if (cs_s2_q) begin
      cnt_d         = 3'd0;
      frame_error_d = (cnt_q != 3'd0);
    end else if (sclk_rise_s) begin
      shift_d = {shift_q[6:0], sdin_s2_q};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        rx_done_d = 1'b1;
        rx_byte_d = {shift_q[6:0], sdin_s2_q};
        rx_dc_d   = dc_s2_q;
      end else begin
        rx_done_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (panel_rst) begin
      shift_q        <= 8'h00;
      cnt_q          <= 3'd0;
      rx_done_q      <= 1'b0;
      rx_byte_q      <= 8'h00;
      rx_dc_q        <= 1'b0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= 8'h00;
      byte_is_data_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      shift_q        <= shift_d;
      cnt_q          <= cnt_d;
      rx_done_q      <= rx_done_d;
      rx_byte_q      <= rx_byte_d;
      rx_dc_q        <= rx_dc_d;
      byte_valid_q   <= byte_valid_d;
      byte_data_q    <= byte_data_d;
      byte_is_data_q <= byte_is_data_d;
      frame_error_q  <= frame_error_d;
    end
  end

  assign byte_valid   = byte_valid_q;
  assign byte_data    = byte_data_q;
  assign byte_is_data = byte_is_data_q;
  assign frame_error  = frame_error_q;

endmodule

// File: rtl/ssd1309_spi_sink.sv
// SSD1309 display-side SPI endpoint: decodes addressing commands and emits
// framebuffer writes for pixel bytes using horizontal addressing.
module ssd1309_spi_sink
  import ssd1309_pkg::*;
#(
  parameter int COLS  = 128,
  parameter int PAGES = 8
) (
  input  logic              clk,
  input  logic              reset,
  ssd1309_spi_sink_if.slave spi,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  output logic              byte_is_data,
  output logic              fb_we,
  output logic [7:0]        fb_xpos,
  output logic [7:0]        fb_ypos,
  output logic [7:0]        fb_din,
  output logic              frame_done,
  output logic              frame_error
);

  localparam int CW = (COLS  > 1) ? $clog2(COLS)  : 1;
  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam logic [7:0] COL_MAX8  = 8'(COLS - 1);
  localparam logic [7:0] PAGE_MAX8 = 8'(PAGES - 1);

  logic          panel_rst_s;
  logic [CW-1:0] col_arg_s;
  logic [PW-1:0] page_arg_s;

  cmd_state_e    state_q, state_d;
  logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic          fb_we_q, fb_we_d;
  logic [7:0]    fb_xpos_q, fb_xpos_d, fb_ypos_q, fb_ypos_d, fb_din_q, fb_din_d;
  logic          frame_done_q, frame_done_d;

  spi_byte_rx u_rx (
    .clk          (clk),
    .reset        (reset),
    .spi          (spi),
    .panel_rst    (panel_rst_s),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .frame_error  (frame_error)
  );

  assign col_arg_s  = CW'(clamp_arg(byte_data, COL_MAX8));
  assign page_arg_s = PW'(clamp_arg(byte_data, PAGE_MAX8));

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_d       = page_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    fb_we_d      = 1'b0;
    fb_xpos_d    = fb_xpos_q;
    fb_ypos_d    = fb_ypos_q;
    fb_din_d     = fb_din_q;
    frame_done_d = 1'b0;
    // Pixel bytes never move the command FSM, even while it waits for an argument.
    if (byte_valid && byte_is_data) begin
      fb_we_d   = 1'b1;
      fb_xpos_d = 8'(col_q);
      fb_ypos_d = 8'({page_q, 3'b000});
      fb_din_d  = byte_data;
      if (col_q == col_end_q) begin
        col_d = col_start_q;
        if (page_q == page_end_q) begin
          page_d       = page_start_q;
          frame_done_d = 1'b1;
        end else begin
          page_d = page_q + PW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end else if (byte_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_data == CMD_COL_ADDR)       state_d = ST_COL_S;
          else if (byte_data == CMD_PAGE_ADDR) state_d = ST_PG_S;
          else if (takes_one_arg(byte_data))   state_d = ST_SKIP1;
          else                                 state_d = ST_IDLE;
        end
        ST_COL_S: begin
          col_start_d = col_arg_s;
          state_d     = ST_COL_E;
        end
        ST_COL_E: begin
          if (col_arg_s < col_start_q) col_end_d = col_start_q;
          else                         col_end_d = col_arg_s;
          col_d   = col_start_q;
          state_d = ST_IDLE;
        end
        ST_PG_S: begin
          page_start_d = page_arg_s;
          state_d      = ST_PG_E;
        end
        ST_PG_E: begin
          if (page_arg_s < page_start_q) page_end_d = page_start_q;
          else                           page_end_d = page_arg_s;
          page_d  = page_start_q;
          state_d = ST_IDLE;
        end
        ST_SKIP1: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (panel_rst_s) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      col_start_q  <= '0;
      col_end_q    <= CW'(COLS - 1);
      page_q       <= '0;
      page_start_q <= '0;
      page_end_q   <= PW'(PAGES - 1);
      fb_we_q      <= 1'b0;
      fb_xpos_q    <= 8'h00;
      fb_ypos_q    <= 8'h00;
      fb_din_q     <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_q       <= page_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      fb_we_q      <= fb_we_d;
      fb_xpos_q    <= fb_xpos_d;
      fb_ypos_q    <= fb_ypos_d;
      fb_din_q     <= fb_din_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_xpos    = fb_xpos_q;
  assign fb_ypos    = fb_ypos_q;
  assign fb_din     = fb_din_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd1309_spi_sink.sv
// Drives SPI traffic into ssd1309_spi_sink and compares received bytes and
// framebuffer writes against a command-stream reference model.
module tb_ssd1309_spi_sink;

  logic       clk;
  logic       reset;
  logic       byte_valid, byte_is_data, fb_we, frame_done, frame_error;
  logic [7:0] byte_data, fb_xpos, fb_ypos, fb_din;

  ssd1309_spi_sink_if spi_if ();

  ssd1309_spi_sink #(.COLS(128), .PAGES(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .spi          (spi_if.slave),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .fb_we        (fb_we),
    .fb_xpos      (fb_xpos),
    .fb_ypos      (fb_ypos),
    .fb_din       (fb_din),
    .frame_done   (frame_done),
    .frame_error  (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int half     = 4;

  // observed: {is_data, byte} and {frame_done, x, y, din}
  logic [8:0]  obs_bytes[$];
  logic [24:0] obs_wr[$];
  logic [8:0]  exp_bytes[$];
  logic [24:0] exp_wr[$];
  int obs_fe = 0, exp_fe = 0, obs_fd = 0, exp_fd = 0;

  // model state: address window and a buffer of the command being collected
  int m_col, m_page, m_cs, m_ce, m_ps, m_pe;
  logic [7:0] cmd_buf[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (byte_valid)  obs_bytes.push_back({byte_is_data, byte_data});
    if (fb_we)       obs_wr.push_back({frame_done, fb_xpos, fb_ypos, fb_din});
    if (frame_error) obs_fe++;
    if (frame_done)  obs_fd++;
  end

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_col = 0; m_page = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    cmd_buf.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input logic isdata);
    int need;
    logic fd;
    exp_bytes.push_back({isdata, b});
    if (isdata) begin
      fd = (m_col == m_ce) && (m_page == m_pe);
      exp_wr.push_back({fd, 8'(m_col), 8'(m_page * 8), b});
      if (fd) exp_fd++;
      if (m_col == m_ce) begin
        m_col  = m_cs;
        m_page = (m_page == m_pe) ? m_ps : m_page + 1;
      end else begin
        m_col = m_col + 1;
      end
    end else begin
      cmd_buf.push_back(b);
      if (cmd_buf[0] == 8'h21 || cmd_buf[0] == 8'h22) need = 3;
      else if (cmd_buf[0] inside {8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB}) need = 2;
      else need = 1;
      if (need == 3 && cmd_buf.size() == 2) begin
        if (cmd_buf[0] == 8'h21) m_cs = min_i(int'(b), 127);
        else                     m_ps = min_i(int'(b), 7);
      end
      if (need == 3 && cmd_buf.size() == 3) begin
        if (cmd_buf[0] == 8'h21) begin
          m_ce = min_i(int'(b), 127); if (m_ce < m_cs) m_ce = m_cs; m_col = m_cs;
        end else begin
          m_pe = min_i(int'(b), 7); if (m_pe < m_ps) m_pe = m_ps; m_page = m_ps;
        end
      end
      if (cmd_buf.size() == need) cmd_buf.delete();
    end
  endtask

  task automatic shift_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_if.sdin = b[i];
      repeat (half) @(posedge clk);
      spi_if.sclk = 1'b1;
      repeat (half) @(posedge clk);
      spi_if.sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic isdata);
    spi_if.cs = 1'b0;
    spi_if.dc = isdata;
    shift_bits(b, 8);
    model_byte(b, isdata);
  endtask

  task automatic drain(input string tag);
    repeat (12) @(posedge clk);
    check_val({tag, "_nbytes"}, obs_bytes.size(), exp_bytes.size());
    while (obs_bytes.size() > 0 && exp_bytes.size() > 0)
      check_val({tag, "_byte"}, 32'(obs_bytes.pop_front()), 32'(exp_bytes.pop_front()));
    check_val({tag, "_nwrites"}, obs_wr.size(), exp_wr.size());
    while (obs_wr.size() > 0 && exp_wr.size() > 0)
      check_val({tag, "_write"}, 32'(obs_wr.pop_front()), 32'(exp_wr.pop_front()));
    obs_bytes.delete(); exp_bytes.delete(); obs_wr.delete(); exp_wr.delete();
    check_val({tag, "_frame_err_cnt"}, obs_fe, exp_fe);
    check_val({tag, "_frame_done_cnt"}, obs_fd, exp_fd);
  endtask

  task automatic check_outputs_zero(input string tag);
    @(negedge clk);
    check_val({tag, "_outs"},
              {byte_valid, byte_data, byte_is_data, fb_we, fb_xpos, fb_ypos, fb_din, frame_done, frame_error},
              '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (4) @(posedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
  endtask

  logic [7:0]  pool[12] = '{8'h21, 8'h22, 8'h20, 8'h81, 8'h8D, 8'hA8,
                            8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'hAE};
  logic [24:0] last_w;
  logic [7:0]  rb;

  initial begin
    reset = 1'b1;
    spi_if.sclk = 1'b0; spi_if.sdin = 1'b0; spi_if.dc = 1'b0;
    spi_if.cs = 1'b1;   spi_if.res = 1'b1;
    model_reset();

    // single command byte at clk/8
    do_reset();
    send_byte(8'hAE, 1'b0);
    drain("cmd_ae");

    // windowed writes, sclk at clk/4 from here on
    half = 2;
    send_byte(8'h21, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
    send_byte(8'hA5, 1'b1); send_byte(8'h5A, 1'b1);
    send_byte(8'hFF, 1'b1); send_byte(8'h00, 1'b1);
    repeat (12) @(posedge clk);
    check_val("win_first_write", 32'(obs_wr[0]), {7'd0, 1'b0, 8'd16, 8'd16, 8'hA5});
    check_val("win_last_write", 32'(obs_wr[3]), {7'd0, 1'b1, 8'd17, 8'd24, 8'h00});
    drain("window");

    // full frame from reset
    do_reset();
    exp_fd = 0; obs_fd = 0;
    for (int i = 0; i < 1024; i++) send_byte(8'($urandom), 1'b1);
    repeat (12) @(posedge clk);
    last_w = obs_wr[obs_wr.size() - 1];
    check_val("frame_last_xy", {16'd0, last_w[23:8]}, {16'd0, 8'd127, 8'd56});
    check_val("frame_done_once", obs_fd, 1);
    drain("frame");
    send_byte(8'h3C, 1'b1);
    repeat (12) @(posedge clk);
    check_val("after_wrap_xy", {16'd0, obs_wr[0][23:8]}, 32'd0);
    drain("wrap");

    // partial byte then deselect
    spi_if.cs = 1'b0; spi_if.dc = 1'b0;
    shift_bits(8'hB7, 5);
    spi_if.cs = 1'b1;
    exp_fe++;
    repeat (6) @(posedge clk);
    send_byte(8'h3C, 1'b0);
    drain("partial");

    // 0x21 swallowed as the contrast argument
    do_reset();
    send_byte(8'h81, 1'b0); send_byte(8'h21, 1'b0); send_byte(8'h77, 1'b1);
    drain("skip_arg");

    // panel reset mid-byte while waiting for the column end
    send_byte(8'h21, 1'b0); send_byte(8'h05, 1'b0);
    send_byte(8'h22, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
    send_byte(8'h21, 1'b0); send_byte(8'h40, 1'b0);
    drain("pre_res");
    spi_if.dc = 1'b0;
    shift_bits(8'hC3, 4);
    spi_if.res = 1'b0;
    repeat (4) @(posedge clk);
    check_outputs_zero("res_low");
    spi_if.res = 1'b1;
    model_reset();
    repeat (4) @(posedge clk);
    spi_if.cs = 1'b1;
    repeat (6) @(posedge clk);
    send_byte(8'h99, 1'b1);
    drain("res");

    // randomized mixed traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 30) begin
        if ($urandom_range(0, 3) == 0) rb = 8'($urandom);
        else                           rb = pool[$urandom_range(0, 11)];
        send_byte(rb, 1'b0);
      end else begin
        send_byte(8'($urandom), 1'b1);
      end
    end
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ssd1309_spi_sink.md
Name: ssd1309_spi_sink

Overview:
- Display-side endpoint of the 4-wire SPI link driven by ssd1309_driver (sclk/sdin/dc/cs/res); behaves as an SSD1309 controller would.
- Oversamples the SPI pins in the clk domain, assembles MSB-first bytes and splits them into command and pixel data.
- Decodes the addressing commands and turns pixel data into framebuffer_monochrome writes (x, y, 8-pixel byte), so a loopback bench or a second board can mirror the panel contents.

Parameters:
- COLS, 128, panel width in columns; column counter range 0..COLS-1.
- PAGES, 8, panel height in 8-row pages; page counter range 0..PAGES-1.

Ports:
- clk  in  1  system clock (27 MHz); sclk must be at most clk/4.
- reset  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock (OLED d0); sdin sampled on its rising edge.
- sdin  in  1  SPI data (OLED d1), MSB first.
- dc  in  1  0 = command byte, 1 = pixel data byte.
- cs  in  1  active-low chip select.
- res  in  1  active-low panel reset; same effect as reset.
- byte_valid  out  1  one-cycle strobe: a byte was received.
- byte_data  out  8  received byte; held until the next byte_valid.
- byte_is_data  out  1  dc as sampled on bit 0 of the byte.
- fb_we  out  1  one-cycle framebuffer write strobe.
- fb_xpos  out  8  write column.
- fb_ypos  out  8  write row, equal to page*8.
- fb_din  out  8  pixel byte (bit0 = top row of the page).
- frame_done  out  1  strobe when the write wraps from (col_end, page_end).
- frame_error  out  1  strobe when cs rises with 1..7 bits pending.

Behaviour:
- Synchronisers: sclk, sdin, dc, cs and res each pass through 2 flip-flops. sclk_rise = s2 & ~s3.
- Shift register: while cs_sync is low, each sclk_rise shifts sdin into bit0. A 3-bit counter tracks bits received.
- Byte completion: on the 8th rise, the byte and dc are latched. byte_valid goes high the following cycle, i.e. 4 clk edges after the pin rise is first sampled (+1 cycle sampling jitter).
- cs high: clears the bit counter. If the counter was nonzero, frame_error pulses once and the partial byte is discarded. Command FSM state and addresses are kept.
- Reset: reset or res_sync low forces all of the following. Overlapping reset and res are equivalent.
  - Outputs: all outputs 0.
  - Shift state: shift register and bit counter cleared.
  - FSM: returns to IDLE.
  - Addresses: col=0, page=0, col_start=0, col_end=COLS-1, page_start=0, page_end=PAGES-1.
  - Mid-byte reset: a reset during a byte aborts it silently, with no frame_error.
- Command FSM, advanced only on command bytes (byte_is_data=0):
  - IDLE, 0x21 -> COL_S -> COL_E -> IDLE. Latches col_start and col_end, then loads col=col_start.
  - IDLE, 0x22 -> PG_S -> PG_E -> IDLE. Latches page_start and page_end, then loads page=page_start.
  - IDLE, one of 0x20, 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB -> SKIP1 -> IDLE. Exactly one argument byte is consumed and ignored.
  - IDLE, any other command: single-byte, ignored, stays in IDLE.
  - Argument range: out-of-range arguments are clamped to COLS-1 (columns) or PAGES-1 (pages). If end < start, end is set to start.
- Data bytes (byte_is_data=1), in any FSM state:
  - Write: the cycle after byte_valid, fb_we=1 with fb_xpos=col, fb_ypos=page*8, fb_din=byte_data.
  - Address advance (horizontal mode only):
    - col == col_end: col is reloaded to col_start and the page advances.
    - page == page_end on that wrap: page is reloaded to page_start, and frame_done pulses in the same cycle as fb_we.
    - otherwise col increments.
  - FSM interaction: a data byte arriving while the FSM waits for an argument does not advance the FSM.
- Throughput: consecutive bytes arrive at least 32 clk apart at sclk ≤ clk/4, so there is no backpressure and no buffering.

Decomposition:
- ssd1309_pkg holds:
  - command opcodes: CMD_COL_ADDR=0x21, CMD_PAGE_ADDR=0x22;
  - the single-argument opcode list;
  - the FSM state enum.
- Sub-module spi_byte_rx (synchronisers, shift register, bit counter, frame_error, byte_valid). The top handles the FSM and addressing.

Test Plan:
- Reset then cmd 0xAE at sclk=clk/8 -> byte_valid with byte_data=0xAE, byte_is_data=0; fb_we stays 0.
- Cmds 0x21,0x10,0x11; 0x22,0x02,0x03; then data 0xA5,0x5A,0xFF,0x00 -> fb_we writes (x,y) = (16,16), (17,16), (16,24), (17,24) with those bytes. frame_done pulses on the 4th write.
- From reset, 1024 data bytes -> the last write is at x=127, y=56; frame_done pulses exactly once; the next write is at (0,0).
- cs rises after 5 bits, then a full byte 0x3C -> one frame_error pulse; the next byte_valid shows 0x3C.
- Cmd 0x81, 0x21 (contrast) then data 0x77 -> 0x21 is treated as an argument, so no column FSM entry; 0x77 is written at (0,0).
- res pulled low mid-byte and mid-COL_E -> no byte_valid; after release, data is written to (0,0); no frame_error.
